// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared widths, RV32 load/store size codes and LSU FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    // Default byte-address and data-word widths of the core/RAM interface
    localparam int API_ADDR_WIDTH = 32;
    localparam int API_DATA_WIDTH = 32;

    // RV32 funct3 size/sign codes for loads and stores
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // LSU sequencing states, explicitly encoded
    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_ISSUE = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_align
// Description : Combinational byte-lane logic: legality, store write mask,
//               store lane replication and load extraction/extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = API_DATA_WIDTH
) (
    input  logic [2:0]            funct3,
    input  logic                  we,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            wr_mask,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  legal
);

    logic [DATA_WIDTH-1:0] w_shifted;

    // Bring the addressed byte/half down to bit 0 of the read word
    assign w_shifted = rdata >> {offset, 3'b000};

    // Decode size/sign and produce lane mask, replicated store data and extended load data
    always_comb begin
        legal      = 1'b0;
        wr_mask    = 4'b0000;
        store_data = '0;
        load_data  = '0;
        case (funct3)
            LSU_B: begin
                legal      = 1'b1;
                wr_mask    = 4'b0001 << offset;
                store_data = {4{wdata[7:0]}};
                load_data  = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            end
            LSU_H: begin
                legal      = ~offset[0];
                wr_mask    = 4'b0011 << offset;
                store_data = {2{wdata[15:0]}};
                load_data  = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            end
            LSU_W: begin
                legal      = (offset == 2'b00);
                wr_mask    = 4'b1111;
                store_data = wdata;
                load_data  = w_shifted;
            end
            LSU_BU: begin
                // Unsigned sizes exist only for loads
                legal      = ~we;
                load_data  = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
            end
            LSU_HU: begin
                legal      = ~we & ~offset[0];
                load_data  = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
            end
            default: begin
                legal      = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : RV32 load/store unit driving a single-port byte-masked RAM
//               with a one-cycle registered read; valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = API_ADDR_WIDTH,
    parameter int DATA_WIDTH = API_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [3:0]            mem_wr_mask_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    lsu_state_t            r_state;
    lsu_state_t            w_state_nxt;
    logic [1:0]            r_offset;
    logic [2:0]            r_funct3;
    logic                  r_we;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_mem_en;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic [3:0]            r_mem_wr_mask;
    logic                  w_rsp_err_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic                  w_mem_en_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_address_nxt;
    logic [DATA_WIDTH-1:0] w_mem_data_nxt;
    logic [3:0]            w_mem_wr_mask_nxt;
    logic                  w_idle;
    logic                  w_accept;
    logic [2:0]            w_sel_funct3;
    logic [1:0]            w_sel_offset;
    logic                  w_sel_we;
    logic [3:0]            w_mask;
    logic [DATA_WIDTH-1:0] w_store_data;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_legal;

    assign w_idle      = (r_state == LSU_IDLE);
    assign w_accept    = req_valid_i & w_idle;
    assign req_ready_o = w_idle;
    assign rsp_valid_o = (r_state == LSU_RESP);

    // While idle the lane logic looks at the live request; afterwards at the captured fields
    assign w_sel_funct3 = w_idle ? req_funct3_i    : r_funct3;
    assign w_sel_offset = w_idle ? req_addr_i[1:0] : r_offset;
    assign w_sel_we     = w_idle ? req_we_i        : r_we;

    mem_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .funct3     (w_sel_funct3),
        .we         (w_sel_we),
        .offset     (w_sel_offset),
        .wdata      (req_wdata_i),
        .rdata      (mem_data_i),
        .wr_mask    (w_mask),
        .store_data (w_store_data),
        .load_data  (w_load_data),
        .legal      (w_legal)
    );

    // Next state, next response and next RAM port values; RAM port defaults to idle
    always_comb begin
        w_state_nxt       = r_state;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_mem_en_nxt      = 1'b0;
        w_mem_address_nxt = '0;
        w_mem_data_nxt    = '0;
        w_mem_wr_mask_nxt = 4'b0000;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_state_nxt       = LSU_ISSUE;
                        w_mem_en_nxt      = 1'b1;
                        w_mem_address_nxt = req_addr_i;
                        if (req_we_i) begin
                            w_mem_data_nxt    = w_store_data;
                            w_mem_wr_mask_nxt = w_mask;
                        end
                    end else begin
                        // Illegal request answers immediately without touching the RAM
                        w_state_nxt     = LSU_RESP;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end
            LSU_ISSUE: begin
                if (r_we) begin
                    w_state_nxt     = LSU_RESP;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_state_nxt     = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                w_state_nxt     = LSU_RESP;
                w_rsp_err_nxt   = 1'b0;
                w_rsp_rdata_nxt = w_load_data;
            end
            LSU_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt     = LSU_IDLE;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = LSU_IDLE;
            end
        endcase
    end

    // State, response and RAM port registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= LSU_IDLE;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_mem_en      <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wr_mask <= 4'b0000;
        end else begin
            r_state       <= w_state_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_mem_en      <= w_mem_en_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_data    <= w_mem_data_nxt;
            r_mem_wr_mask <= w_mem_wr_mask_nxt;
        end
    end

    // Capture the request fields needed after acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_offset <= 2'b00;
            r_funct3 <= 3'b000;
            r_we     <= 1'b0;
        end else if (w_accept) begin
            r_offset <= req_addr_i[1:0];
            r_funct3 <= req_funct3_i;
            r_we     <= req_we_i;
        end
    end

    assign rsp_err_o     = r_rsp_err;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign mem_en_o      = r_mem_en;
    assign mem_address_o = r_mem_address;
    assign mem_data_o    = r_mem_data;
    assign mem_wr_mask_o = r_mem_wr_mask;

endmodule
`default_nettype wire
